// File: rtl/pq_front_end_pkg.sv
// Shared types and width helpers for the priority-queue front end.
package pq_front_end_pkg;

  // Command issued to the register-array queue in a given cycle.
  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_ENQ     = 2'd1,
    CMD_POP     = 2'd2,
    CMD_REPLACE = 2'd3
  } q_cmd_e;

  // Number of bits needed to hold values 0..max_val (never less than one bit).
  function automatic int width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pq_sync_fifo.sv
// Small synchronous FIFO with a combinational head view.
// Depth must be a power of two; pointers carry one wrap bit to tell full from empty.
module pq_sync_fifo
  import pq_front_end_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = width_for(FIFO_DEPTH - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Read and write pointers; reset empties the FIFO without touching storage.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Key storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_CLK) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pq_front_end.sv
// Ingress/egress controller in front of the register-array priority queue.
// Buffers pushed keys, arbitrates one queue command per cycle (merging a push
// with a pop into a replace), holds the popped head in a valid/ready slot and
// spaces queue commands by a programmable settle gap.
module pq_front_end
  import pq_front_end_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 0,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop_valid,
  output logic                  o_pop_ready,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_q_wrt,
  output logic                  o_q_read,
  output logic [DATA_WIDTH-1:0] o_q_data,
  input  logic                  i_q_full,
  input  logic                  i_q_empty,
  input  logic [DATA_WIDTH-1:0] i_q_head,
  output logic [CNT_WIDTH-1:0]  o_zero_drop_cnt
);

  localparam int                  SW          = width_for(SETTLE_CYCLES);
  localparam logic [SW-1:0]       SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0]       SETTLE_ONE  = SW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  // Saturating increment for the zero-drop counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  push_hs;
  logic                  push_zero;
  logic                  cmd_ok;
  logic                  pop_hs;
  q_cmd_e                q_cmd;
  logic [SW-1:0]         settle_cnt_p0;
  logic                  resp_vld_p1;
  logic [DATA_WIDTH-1:0] resp_data_p1;
  logic [CNT_WIDTH-1:0]  zero_cnt;

  // Push side: zero keys mark empty queue slots, so they never enter the FIFO.
  assign o_push_ready = !fifo_full;
  assign push_hs      = i_push_valid && o_push_ready;
  assign push_zero    = (i_push_data == '0);
  assign fifo_wr      = push_hs && !push_zero;

  // Pop gate depends only on state and queue status, never on i_pop_valid.
  assign cmd_ok      = (settle_cnt_p0 == '0);
  assign o_pop_ready = cmd_ok && !i_q_empty && (!resp_vld_p1 || i_resp_ready);
  assign pop_hs      = i_pop_valid && o_pop_ready;

  pq_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .wr_en   (fifo_wr),
    .wr_data (i_push_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Command arbitration: a pop always wins, folding a buffered key into a replace.
  always_comb begin
    q_cmd = CMD_IDLE;
    if (pop_hs) begin
      q_cmd = fifo_empty ? CMD_POP : CMD_REPLACE;
    end else if (cmd_ok && !fifo_empty && !i_q_full) begin
      q_cmd = CMD_ENQ;
    end
  end

  // Queue strobes and data for the selected command.
  always_comb begin
    o_q_wrt  = 1'b0;
    o_q_read = 1'b0;
    o_q_data = '0;
    fifo_rd  = 1'b0;
    unique case (q_cmd)
      CMD_REPLACE: begin
        o_q_wrt  = 1'b1;
        o_q_read = 1'b1;
        o_q_data = fifo_head;
        fifo_rd  = 1'b1;
      end
      CMD_POP: begin
        o_q_read = 1'b1;
      end
      CMD_ENQ: begin
        o_q_wrt  = 1'b1;
        o_q_data = fifo_head;
        fifo_rd  = 1'b1;
      end
      default: begin
        o_q_wrt  = 1'b0;
      end
    endcase
  end

  // Settle gap: reload on every issued command, count down while idle.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      settle_cnt_p0 <= '0;
    end else if (q_cmd != CMD_IDLE) begin
      settle_cnt_p0 <= SETTLE_LOAD;
    end else if (settle_cnt_p0 != '0) begin
      settle_cnt_p0 <= settle_cnt_p0 - SETTLE_ONE;
    end
  end

  // ---- response stage: popped head registered into the valid/ready slot ----
  // A new capture takes precedence over a drain in the same cycle.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      resp_vld_p1  <= 1'b0;
      resp_data_p1 <= '0;
    end else if (q_cmd == CMD_POP || q_cmd == CMD_REPLACE) begin
      resp_vld_p1  <= 1'b1;
      resp_data_p1 <= i_q_head;
    end else if (i_resp_ready) begin
      resp_vld_p1  <= 1'b0;
    end
  end

  assign o_resp_valid = resp_vld_p1;
  assign o_resp_data  = resp_data_p1;

  // Count of discarded zero keys, held at all-ones once saturated.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      zero_cnt <= '0;
    end else if (push_hs && push_zero) begin
      zero_cnt <= sat_inc(zero_cnt);
    end
  end

  assign o_zero_drop_cnt = zero_cnt;

endmodule

// File: tb/tb_pq_front_end.sv
// Directed bench for pq_front_end: two instances (no settle / 8-bit counter,
// and settle of 2 / 2-bit counter) share stimulus; a behavioural model checks
// both every cycle and literal expectations pin the key scenarios.
module tb_pq_front_end;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          i_CLK;
  logic          i_RST;
  logic          i_push_valid;
  logic [DW-1:0] i_push_data;
  logic          i_pop_valid;
  logic          i_resp_ready;
  logic          i_q_full;
  logic          i_q_empty;
  logic [DW-1:0] i_q_head;

  logic          push_ready0, pop_ready0, resp_valid0, q_wrt0, q_read0;
  logic [DW-1:0] resp_data0, q_data0;
  logic [7:0]    zc0;
  logic          push_ready1, pop_ready1, resp_valid1, q_wrt1, q_read1;
  logic [DW-1:0] resp_data1, q_data1;
  logic [1:0]    zc1;

  pq_front_end #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(0), .CNT_WIDTH(8)) dut0 (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_push_valid(i_push_valid), .o_push_ready(push_ready0), .i_push_data(i_push_data),
    .i_pop_valid(i_pop_valid), .o_pop_ready(pop_ready0),
    .o_resp_valid(resp_valid0), .i_resp_ready(i_resp_ready), .o_resp_data(resp_data0),
    .o_q_wrt(q_wrt0), .o_q_read(q_read0), .o_q_data(q_data0),
    .i_q_full(i_q_full), .i_q_empty(i_q_empty), .i_q_head(i_q_head),
    .o_zero_drop_cnt(zc0)
  );

  pq_front_end #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(2), .CNT_WIDTH(2)) dut1 (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_push_valid(i_push_valid), .o_push_ready(push_ready1), .i_push_data(i_push_data),
    .i_pop_valid(i_pop_valid), .o_pop_ready(pop_ready1),
    .o_resp_valid(resp_valid1), .i_resp_ready(i_resp_ready), .o_resp_data(resp_data1),
    .o_q_wrt(q_wrt1), .o_q_read(q_read1), .o_q_data(q_data1),
    .i_q_full(i_q_full), .i_q_empty(i_q_empty), .i_q_head(i_q_head),
    .o_zero_drop_cnt(zc1)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  // Outputs gathered per instance so the model loop can index them.
  logic          d_push_ready [2];
  logic          d_pop_ready  [2];
  logic          d_resp_valid [2];
  logic          d_q_wrt      [2];
  logic          d_q_read     [2];
  logic [DW-1:0] d_resp_data  [2];
  logic [DW-1:0] d_q_data     [2];
  logic [7:0]    d_zc         [2];

  assign d_push_ready[0] = push_ready0;  assign d_push_ready[1] = push_ready1;
  assign d_pop_ready[0]  = pop_ready0;   assign d_pop_ready[1]  = pop_ready1;
  assign d_resp_valid[0] = resp_valid0;  assign d_resp_valid[1] = resp_valid1;
  assign d_q_wrt[0]      = q_wrt0;       assign d_q_wrt[1]      = q_wrt1;
  assign d_q_read[0]     = q_read0;      assign d_q_read[1]     = q_read1;
  assign d_resp_data[0]  = resp_data0;   assign d_resp_data[1]  = resp_data1;
  assign d_q_data[0]     = q_data0;      assign d_q_data[1]     = q_data1;
  assign d_zc[0]         = zc0;          assign d_zc[1]         = {6'b0, zc1};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mf   [2][DEPTH];
  int            mcnt [2];
  int            mset [2];
  bit            mrv  [2];
  logic [DW-1:0] mrd  [2];
  int            mzc  [2];
  bit            started = 1'b0;

  function automatic int settle_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int zmax_of(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      mset[k] = 0;
      mrv[k]  = 1'b0;
      mrd[k]  = '0;
      mzc[k]  = 0;
    end
  endtask

  // Check instance k's outputs for this cycle, then advance the model one clock.
  task automatic model_cycle(input int k);
    bit            e_pr, e_popr, hs, e_wrt, e_read, deq;
    logic [DW-1:0] e_data;
    e_pr   = (mcnt[k] != DEPTH);
    e_popr = (mset[k] == 0) && !i_q_empty && (!mrv[k] || i_resp_ready);
    hs     = i_pop_valid && e_popr;
    e_wrt  = 1'b0;
    e_read = 1'b0;
    e_data = '0;
    deq    = 1'b0;
    if (hs) begin
      e_read = 1'b1;
      if (mcnt[k] > 0) begin
        e_wrt  = 1'b1;
        e_data = mf[k][0];
        deq    = 1'b1;
      end
    end else if (mset[k] == 0 && mcnt[k] > 0 && !i_q_full) begin
      e_wrt  = 1'b1;
      e_data = mf[k][0];
      deq    = 1'b1;
    end

    chk($sformatf("model%0d push_ready", k), 32'(d_push_ready[k]), 32'(e_pr));
    chk($sformatf("model%0d pop_ready", k),  32'(d_pop_ready[k]),  32'(e_popr));
    chk($sformatf("model%0d q_wrt", k),      32'(d_q_wrt[k]),      32'(e_wrt));
    chk($sformatf("model%0d q_read", k),     32'(d_q_read[k]),     32'(e_read));
    chk($sformatf("model%0d q_data", k),     32'(d_q_data[k]),     32'(e_data));
    chk($sformatf("model%0d resp_valid", k), 32'(d_resp_valid[k]), 32'(mrv[k]));
    if (mrv[k]) chk($sformatf("model%0d resp_data", k), 32'(d_resp_data[k]), 32'(mrd[k]));
    chk($sformatf("model%0d zero_cnt", k),   32'(d_zc[k]),         32'(mzc[k]));

    if (deq) begin
      for (int i = 0; i < DEPTH - 1; i++) mf[k][i] = mf[k][i+1];
      mcnt[k]--;
    end
    if (i_push_valid && e_pr) begin
      if (i_push_data == '0) begin
        if (mzc[k] < zmax_of(k)) mzc[k]++;
      end else begin
        mf[k][mcnt[k]] = i_push_data;
        mcnt[k]++;
      end
    end
    if (hs) begin
      mrv[k] = 1'b1;
      mrd[k] = i_q_head;
    end else if (i_resp_ready) begin
      mrv[k] = 1'b0;
    end
    if (e_wrt || e_read) mset[k] = settle_of(k);
    else if (mset[k] > 0) mset[k]--;
  endtask

  // Compare process: inputs are stable at the falling edge.
  always @(negedge i_CLK) begin
    if (started) begin
      model_cycle(0);
      model_cycle(1);
    end
    if (i_RST) begin
      model_reset();
      started = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge i_CLK);
  endtask

  initial begin
    i_RST        = 1'b1;
    i_push_valid = 1'b0;
    i_push_data  = '0;
    i_pop_valid  = 1'b0;
    i_resp_ready = 1'b1;
    i_q_full     = 1'b0;
    i_q_empty    = 1'b1;
    i_q_head     = '0;

    mid(); tick();
    // Reset state
    mid();
    chk("rst push_ready", 32'(push_ready0), 1);
    chk("rst pop_ready",  32'(pop_ready0),  0);
    chk("rst resp_valid", 32'(resp_valid0), 0);
    chk("rst resp_data",  32'(resp_data0),  0);
    chk("rst q_wrt",      32'(q_wrt0),      0);
    chk("rst q_read",     32'(q_read0),     0);
    chk("rst q_data",     32'(q_data0),     0);
    chk("rst zero_cnt",   32'(zc0),         0);
    tick();

    // Push 5, 9, 3 back to back
    i_RST = 1'b0; i_push_valid = 1'b1; i_push_data = 16'd5;
    mid(); chk("enq first-cycle wrt", 32'(q_wrt0), 0); tick();
    i_push_data = 16'd9;
    mid();
    chk("enq5 wrt", 32'(q_wrt0), 1); chk("enq5 data", 32'(q_data0), 5); chk("enq5 read", 32'(q_read0), 0);
    chk("settle enq5 wrt", 32'(q_wrt1), 1);
    tick();
    i_push_data = 16'd3;
    mid();
    chk("enq9 wrt", 32'(q_wrt0), 1); chk("enq9 data", 32'(q_data0), 9);
    chk("settle gap1 wrt", 32'(q_wrt1), 0);
    tick();
    i_push_valid = 1'b0; i_push_data = '0;
    mid();
    chk("enq3 wrt", 32'(q_wrt0), 1); chk("enq3 data", 32'(q_data0), 3); chk("enq3 read", 32'(q_read0), 0);
    chk("settle gap2 wrt", 32'(q_wrt1), 0);
    tick();
    mid();
    chk("enq done wrt", 32'(q_wrt0), 0);
    chk("settle enq9 wrt", 32'(q_wrt1), 1); chk("settle enq9 data", 32'(q_data1), 9);
    tick();
    repeat (6) begin mid(); tick(); end

    // Zero keys are dropped and counted
    for (int i = 0; i < 5; i++) begin
      i_push_valid = 1'b1; i_push_data = '0;
      mid();
      chk("zero push_ready", 32'(push_ready0), 1);
      chk("zero no wrt", 32'(q_wrt0), 0);
      if (i == 3) begin
        chk("zero cnt after 3", 32'(zc0), 3);
        chk("zero cnt2 after 3", 32'(zc1), 3);
      end
      tick();
    end
    i_push_valid = 1'b0;
    mid();
    chk("zero cnt after 5", 32'(zc0), 5);
    chk("zero cnt2 saturated", 32'(zc1), 3);
    tick();

    // Replace: FIFO holds 4, queue head 9
    i_push_valid = 1'b1; i_push_data = 16'd4; i_q_full = 1'b1;
    mid(); chk("full holds key", 32'(q_wrt0), 0); tick();
    i_push_valid = 1'b0; i_q_empty = 1'b0; i_q_head = 16'd9; i_pop_valid = 1'b1;
    mid();
    chk("repl pop_ready", 32'(pop_ready0), 1);
    chk("repl wrt", 32'(q_wrt0), 1); chk("repl read", 32'(q_read0), 1); chk("repl data", 32'(q_data0), 4);
    tick();
    i_pop_valid = 1'b0; i_q_full = 1'b0; i_q_empty = 1'b1;
    mid();
    chk("repl resp_valid", 32'(resp_valid0), 1); chk("repl resp_data", 32'(resp_data0), 9);
    tick();

    // Pop against an empty queue stalls until a key is enqueued
    i_pop_valid = 1'b1;
    mid();
    chk("empty pop_ready", 32'(pop_ready0), 0);
    chk("empty no wrt", 32'(q_wrt0), 0); chk("empty no read", 32'(q_read0), 0);
    tick();
    i_push_valid = 1'b1; i_push_data = 16'd7;
    mid(); chk("empty push no read", 32'(q_read0), 0); tick();
    i_push_valid = 1'b0; i_push_data = '0;
    mid();
    chk("enq7 wrt", 32'(q_wrt0), 1); chk("enq7 read", 32'(q_read0), 0); chk("enq7 data", 32'(q_data0), 7);
    tick();
    i_q_empty = 1'b0; i_q_head = 16'd7;
    mid();
    chk("pop7 read", 32'(q_read0), 1); chk("pop7 wrt", 32'(q_wrt0), 0); chk("pop7 data", 32'(q_data0), 0);
    chk("settle pop held", 32'(q_read1), 0);
    tick();
    i_q_head = 16'd11;
    mid();
    chk("pop7 resp", 32'(resp_data0), 7); chk("pop7 resp_valid", 32'(resp_valid0), 1);
    tick();
    i_q_head = 16'd12;
    mid(); chk("settle pop issued", 32'(q_read1), 1); tick();
    i_pop_valid = 1'b0;
    mid();
    chk("settle pop resp_valid", 32'(resp_valid1), 1); chk("settle pop resp", 32'(resp_data1), 12);
    tick();

    // Response backpressure
    i_resp_ready = 1'b0; i_pop_valid = 1'b1; i_q_head = 16'd20;
    mid(); chk("bp pop read", 32'(q_read0), 1); tick();
    i_q_head = 16'd21;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("bp pop_ready", 32'(pop_ready0), 0);
      chk("bp resp_data", 32'(resp_data0), 20);
      tick();
    end
    i_resp_ready = 1'b1; i_q_head = 16'd30;
    mid();
    chk("drain pop_ready", 32'(pop_ready0), 1); chk("drain read", 32'(q_read0), 1);
    tick();
    i_pop_valid = 1'b0;
    mid();
    chk("recap resp_valid", 32'(resp_valid0), 1); chk("recap resp_data", 32'(resp_data0), 30);
    chk("recap2 resp_data", 32'(resp_data1), 30);
    tick();

    // Queue full: FIFO fills, then push backpressures
    i_q_full = 1'b1; i_q_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_push_valid = 1'b1; i_push_data = 16'(i + 1);
      mid();
      chk("fill push_ready", 32'(push_ready0), 1);
      chk("fill no wrt", 32'(q_wrt0), 0);
      tick();
    end
    i_push_data = 16'd5;
    mid();
    chk("fifo full push_ready", 32'(push_ready0), 0);
    chk("fifo full push_ready2", 32'(push_ready1), 0);
    tick();
    i_push_valid = 1'b0; i_q_full = 1'b0;
    mid(); chk("unfull enq data", 32'(q_data0), 1); chk("unfull enq wrt", 32'(q_wrt0), 1); tick();
    i_pop_valid = 1'b1; i_q_head = 16'd40;
    mid();
    chk("late repl wrt", 32'(q_wrt0), 1); chk("late repl read", 32'(q_read0), 1); chk("late repl data", 32'(q_data0), 2);
    tick();

    // Mid-operation reset discards buffered keys and the pending response
    i_RST = 1'b1; i_pop_valid = 1'b0;
    mid(); tick();
    i_RST = 1'b0; i_q_empty = 1'b1;
    mid();
    chk("mid rst resp_valid", 32'(resp_valid0), 0);
    chk("mid rst resp_data",  32'(resp_data0),  0);
    chk("mid rst no wrt",     32'(q_wrt0),      0);
    chk("mid rst push_ready", 32'(push_ready0), 1);
    chk("mid rst zero_cnt",   32'(zc0),         0);
    tick();
    repeat (3) begin mid(); tick(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pq_front_end.md
Name: pq_front_end

Overview:
- Ingress/egress controller sitting directly in front of the register-array priority queue.
- Buffers incoming keys in a small push FIFO and accepts pop requests.
- Issues at most one write/read command per cycle to the queue, merging a push and a pop into a replace.
- Registers the popped head into a valid/ready response slot, filters zero keys (zero marks an empty slot inside the queue), and enforces a configurable settle gap between queue commands.

Parameters:
- DATA_WIDTH, 16, key width; must match the queue.
- FIFO_DEPTH, 4, push FIFO entries; power of two, >= 2.
- SETTLE_CYCLES, 0, minimum idle cycles between consecutive queue commands.
- CNT_WIDTH, 8, width of the saturating zero-drop counter.

Ports:
- i_CLK  in  1  clock; all logic on rising edge.
- i_RST  in  1  synchronous reset, active-high.
- i_push_valid  in  1  push key offered.
- o_push_ready  out  1  FIFO can take a key.
- i_push_data  in  DATA_WIDTH  push key.
- i_pop_valid  in  1  pop requested.
- o_pop_ready  out  1  pop accepted this cycle when high with i_pop_valid.
- o_resp_valid  out  1  popped key available.
- i_resp_ready  in  1  consumer takes the popped key.
- o_resp_data  out  DATA_WIDTH  popped key.
- o_q_wrt  out  1  drives queue i_wrt.
- o_q_read  out  1  drives queue i_read.
- o_q_data  out  DATA_WIDTH  drives queue i_data.
- i_q_full  in  1  queue o_full.
- i_q_empty  in  1  queue o_empty.
- i_q_head  in  DATA_WIDTH  queue o_data (head).
- o_zero_drop_cnt  out  CNT_WIDTH  saturating count of discarded zero keys.

Behaviour:
- Reset values:
  - FIFO empty; o_push_ready=1.
  - o_pop_ready=0, o_resp_valid=0, o_resp_data=0.
  - o_q_wrt=0, o_q_read=0, o_q_data=0.
  - Settle counter 0; o_zero_drop_cnt=0.
- Reset mid-operation discards FIFO contents and any pending response. The queue itself is not touched by this block.
- Push side:
  - o_push_ready = !fifo_full.
  - An accepted key equal to 0 is dropped, not stored, and increments o_zero_drop_cnt (saturates at all-ones).
  - A nonzero accepted key is written to the FIFO tail.
- Pop gate: cmd_ok = (settle_cnt==0). o_pop_ready = cmd_ok && !i_q_empty && (!o_resp_valid || i_resp_ready). Purely from state and queue inputs, never from i_pop_valid.
- Command selection (combinational, one per cycle), in priority order:
  1. REPLACE: pop handshake && fifo nonempty → o_q_wrt=1, o_q_read=1, o_q_data=FIFO head, FIFO pops.
  2. POP: pop handshake && fifo empty → o_q_read=1, o_q_wrt=0, o_q_data=0.
  3. ENQ: no pop handshake && cmd_ok && fifo nonempty && !i_q_full → o_q_wrt=1, o_q_read=0, o_q_data=FIFO head, FIFO pops.
  4. IDLE: both strobes 0, o_q_data=0.
- A FIFO push and a FIFO pop in the same cycle are both allowed; a push when full is impossible because ready is low.
- Response: on REPLACE or POP, i_q_head is captured into o_resp_data and o_resp_valid=1 next cycle. Hold stable until i_resp_ready. Simultaneous drain and new capture → stays valid with the new data.
- Settle: any non-IDLE command loads settle_cnt=SETTLE_CYCLES; it decrements to 0 each cycle. With SETTLE_CYCLES=0, back-to-back commands are allowed.
- Latency:
  - Key accepted at cycle N is enqueued at N+1 at the earliest.
  - Pop handshake at N gives o_resp_valid at N+1.
- Queue empty with FIFO nonempty: the pop stalls; the FIFO key is enqueued first; the pop becomes eligible after settle.
- Queue full and no pops: the FIFO fills, then push backpressures.

Decomposition:
- Package pq_front_end_pkg: typedef enum q_cmd_e {CMD_IDLE, CMD_ENQ, CMD_POP, CMD_REPLACE}; width helper constants.
- Sub-module pq_sync_fifo: synchronous FIFO (DATA_WIDTH, FIFO_DEPTH) with full/empty, synchronous active-high reset.

Test Plan:
- Reset then push 5,9,3 with queue idle (SETTLE_CYCLES=0) → o_q_wrt high on three consecutive cycles with o_q_data 5,9,3; o_q_read stays 0.
- Push 0 three times → o_push_ready=1, no o_q_wrt, o_zero_drop_cnt=3. With CNT_WIDTH=2, five zero pushes → counter holds 3.
- Pop with i_q_head=9, FIFO holding 4 → same cycle o_q_wrt=o_q_read=1, o_q_data=4; next cycle o_resp_valid=1, o_resp_data=9.
- i_q_empty=1, FIFO empty, i_pop_valid=1 → o_pop_ready=0, no strobes. Push 7 → ENQ of 7; after i_q_empty falls, the pop completes with the response equal to i_q_head.
- i_resp_ready=0 with o_resp_valid=1 → o_pop_ready=0 and o_resp_data stable for 10 cycles; raising i_resp_ready with i_pop_valid=1 → drain and new capture in the same cycle.
- SETTLE_CYCLES=2, FIFO holding 1,2 → ENQs at cycles N and N+3 only; i_q_full=1 → no ENQ and the FIFO fills to FIFO_DEPTH, then o_push_ready=0.
